// File: rtl/xcorr_seq.sv
// rtl/xcorr_seq.sv - sweep sequencer for the four-lane cross-correlation array
//
// Purpose: latches a reference and a signal word on start, then walks the
// array through CLR, every 4-lag SWEEP step and COMMIT. It captures the
// array's best lag and offers it over a valid/ready handshake.
// Optional feature: define XCORR_SEQ_ABORT_EN to add the abort input.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               sweep request (IDLE, or WAIT on the accepting cycle)
//   abort               (XCORR_SEQ_ABORT_EN only) abandon sweep / drop result
//   din_ref, din_sig    words latched on an accepted start
//   busy                high outside IDLE
//   ref_out, sig_out    latched reference, rotated signal to the array
//   arr_ena             array hold (low = stepping)
//   arr_cnt             step counter to the array
//   arr_lag             array's committed best lag
//   lag_out, lag_valid  result and its valid flag
//   lag_ready           consumer accept
module xcorr_seq #(
  parameter int NDATA     = 128,
  parameter int NDATA_LOG = $clog2(NDATA)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
`ifdef XCORR_SEQ_ABORT_EN
  input  logic                 abort,
`endif
  input  logic [NDATA-1:0]     din_ref,
  input  logic [NDATA-1:0]     din_sig,
  output logic                 busy,
  output logic [NDATA-1:0]     ref_out,
  output logic [NDATA-1:0]     sig_out,
  output logic                 arr_ena,
  output logic [NDATA_LOG-1:0] arr_cnt,
  input  logic [NDATA_LOG-1:0] arr_lag,
  output logic [NDATA_LOG-1:0] lag_out,
  output logic                 lag_valid,
  input  logic                 lag_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_SWEEP,
    S_COMMIT,
    S_CAPT,
    S_WAIT
  } state_t;

  state_t               state_q;
  logic                 busy_q;
  logic                 arr_ena_q;
  logic [NDATA_LOG-1:0] arr_cnt_q;
  logic [NDATA_LOG-1:0] arr_cnt_d;
  logic [NDATA_LOG-1:0] lag_out_q;
  logic                 lag_valid_q;
  logic [NDATA-1:0]     ref_q;
  logic [NDATA-1:0]     sig_q;
  logic [NDATA-1:0]     sig_d;
  logic                 last_step;
  logic                 abort_w;

`ifdef XCORR_SEQ_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // The last step is detected explicitly so the counter returns to 0 even
  // when NDATA is not a power of two; for powers of two this is the natural wrap.
  assign last_step = (arr_cnt_q == NDATA_LOG'(NDATA - 4));
  assign arr_cnt_d = last_step ? '0 : arr_cnt_q + NDATA_LOG'(4);

  // Each SWEEP cycle advances the signal by one 4-lag block.
  assign sig_d = {sig_q[NDATA-5:0], sig_q[NDATA-1:NDATA-4]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      arr_ena_q   <= 1'b1;
      arr_cnt_q   <= '0;
      lag_out_q   <= '0;
      lag_valid_q <= 1'b0;
      ref_q       <= '0;
      sig_q       <= '0;
    end else if (abort_w && (state_q != S_IDLE)) begin
      // lag_out keeps its last value; only the handshake and array are parked.
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      arr_ena_q   <= 1'b1;
      arr_cnt_q   <= '0;
      lag_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            ref_q     <= din_ref;
            sig_q     <= din_sig;
            state_q   <= S_CLR;
            busy_q    <= 1'b1;
            arr_ena_q <= 1'b0;
            arr_cnt_q <= '0;
          end
        end
        S_CLR: begin
          state_q   <= S_SWEEP;
          arr_cnt_q <= arr_cnt_d;
        end
        S_SWEEP: begin
          sig_q     <= sig_d;
          arr_cnt_q <= arr_cnt_d;
          if (last_step) state_q <= S_COMMIT;
        end
        S_COMMIT: begin
          state_q   <= S_CAPT;
          arr_ena_q <= 1'b1;
        end
        S_CAPT: begin
          state_q     <= S_WAIT;
          lag_out_q   <= arr_lag;
          lag_valid_q <= 1'b1;
        end
        S_WAIT: begin
          if (lag_ready) begin
            lag_valid_q <= 1'b0;
            if (start) begin
              ref_q     <= din_ref;
              sig_q     <= din_sig;
              state_q   <= S_CLR;
              arr_ena_q <= 1'b0;
              arr_cnt_q <= '0;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q   <= S_IDLE;
          busy_q    <= 1'b0;
          arr_ena_q <= 1'b1;
          arr_cnt_q <= '0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign arr_ena   = arr_ena_q;
  assign arr_cnt   = arr_cnt_q;
  assign lag_out   = lag_out_q;
  assign lag_valid = lag_valid_q;
  assign ref_out   = ref_q;
  assign sig_out   = sig_q;

endmodule

// File: tb/tb_xcorr_seq.sv
// tb/tb_xcorr_seq.sv - self-checking bench for xcorr_seq with a behavioural array model
module tb_xcorr_seq;

  localparam int N     = 128;
  localparam int LW    = $clog2(N);
  localparam int NSTEP = N / 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [N-1:0]  din_ref = '0;
  logic [N-1:0]  din_sig = '0;
  logic          busy;
  logic [N-1:0]  ref_out;
  logic [N-1:0]  sig_out;
  logic          arr_ena;
  logic [LW-1:0] arr_cnt;
  logic [LW-1:0] arr_lag;
  logic [LW-1:0] lag_out;
  logic          lag_valid;
  logic          lag_ready = 1'b0;
`ifdef XCORR_SEQ_ABORT_EN
  logic          abort = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  xcorr_seq #(.NDATA(N)) dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef XCORR_SEQ_ABORT_EN
    .abort(abort),
`endif
    .din_ref(din_ref), .din_sig(din_sig), .busy(busy),
    .ref_out(ref_out), .sig_out(sig_out), .arr_ena(arr_ena),
    .arr_cnt(arr_cnt), .arr_lag(arr_lag), .lag_out(lag_out),
    .lag_valid(lag_valid), .lag_ready(lag_ready)
  );

  function automatic logic [N-1:0] rotl(input logic [N-1:0] x, input int n);
    int m;
    m = n % N;
    if (m == 0) return x;
    return (x << m) | (x >> (N - m));
  endfunction

  function automatic logic [N-1:0] rotr(input logic [N-1:0] x, input int n);
    return rotl(x, (N - (n % N)) % N);
  endfunction

  function automatic logic [N-1:0] rand_word();
    logic [N-1:0] w;
    for (int i = 0; i < N / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // Reference: the lag in 0..N-5 whose left rotation of sig agrees with ref
  // in the most bit positions (first such lag on ties).
  function automatic int ref_lag(input logic [N-1:0] r, input logic [N-1:0] s);
    int best, bl, sc;
    best = -1;
    bl   = 0;
    for (int l = 0; l <= N - 5; l++) begin
      sc = $countones(~(r ^ rotl(s, l)));
      if (sc > best) begin
        best = sc;
        bl   = l;
      end
    end
    return bl;
  endfunction

  // Behavioural four-lane array: lane j scores lag (arr_cnt-4)+j against the
  // presented rotation; clears on the first zero-count step, commits on the next.
  int  m_best;
  int  m_lag;
  int  m_sc;
  bit  m_swept;
  always @(posedge clk) begin
    if (rst) begin
      m_swept = 1'b0;
      m_best  = -1;
      m_lag   = 0;
      arr_lag <= '0;
    end else if (arr_ena) begin
      m_swept = 1'b0;
    end else if (arr_cnt == '0) begin
      if (m_swept) begin
        arr_lag <= LW'(m_lag);
        m_swept = 1'b0;
      end else begin
        m_best = -1;
        m_lag  = 0;
      end
    end else begin
      m_swept = 1'b1;
      for (int j = 0; j < 4; j++) begin
        m_sc = $countones(~(ref_out ^ rotl(sig_out, j)));
        if (m_sc > m_best) begin
          m_best = m_sc;
          m_lag  = int'(arr_cnt) - 4 + j;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, N'(busy), N'(0));
    check({tag, "_arr_ena"}, N'(arr_ena), N'(1));
    check({tag, "_arr_cnt"}, N'(arr_cnt), N'(0));
    check({tag, "_lag_valid"}, N'(lag_valid), N'(0));
    check({tag, "_lag_out"}, N'(lag_out), N'(0));
    check({tag, "_ref_out"}, ref_out, N'(0));
    check({tag, "_sig_out"}, sig_out, N'(0));
  endtask

  // Starts a sweep from IDLE and follows it to lag_valid, checking each cycle.
  task automatic sweep_to_valid(input logic [N-1:0] r, input logic [N-1:0] s,
                                input int exp_lag, input string tag);
    int n, bad_n, rot, ecnt;
    bit eena;
    bad_n = -1;
    din_ref = r;
    din_sig = s;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    din_ref = ~r;
    din_sig = rand_word();
    n = 0;
    while (lag_valid !== 1'b1 && n < 60) begin
      ecnt = (n >= 1 && n <= NSTEP - 1) ? 4 * n : 0;
      eena = (n >= NSTEP + 1);
      rot  = (n == 0) ? 0 : ((n < NSTEP) ? 4 * (n - 1) : 4 * (NSTEP - 1));
      if (n == 5) begin
        check({tag, "_k5_sig"}, sig_out, rotl(s, 16));
        check({tag, "_k5_cnt"}, N'(arr_cnt), N'(20));
      end
      if (bad_n < 0 && (arr_cnt !== LW'(ecnt) || arr_ena !== eena ||
                        sig_out !== rotl(s, rot) || ref_out !== r || busy !== 1'b1))
        bad_n = n;
      tick();
      n++;
    end
    check({tag, "_seq_first_bad_cycle"}, N'(bad_n + 1), N'(0));
    check({tag, "_latency"}, N'(n), N'(NSTEP + 2));
    check({tag, "_lag"}, N'(lag_out), N'(exp_lag));
  endtask

  task automatic accept(input int hold, input string tag);
    repeat (hold) tick();
    lag_ready = 1'b1;
    tick();
    lag_ready = 1'b0;
    check({tag, "_acc_valid"}, N'(lag_valid), N'(0));
    check({tag, "_acc_busy"}, N'(busy), N'(0));
  endtask

  typedef struct {
    int rot;
    int exp_lag;
    int hold;
  } vec_t;

  initial begin
    vec_t         tbl[6];
    logic [N-1:0] r, s, r2;
    int           cnt, bad;
    logic [LW-1:0] held;

    tbl[0] = '{rot: 0,   exp_lag: 0,   hold: 0};
    tbl[1] = '{rot: 1,   exp_lag: 1,   hold: 2};
    tbl[2] = '{rot: 40,  exp_lag: 40,  hold: 0};
    tbl[3] = '{rot: 123, exp_lag: 123, hold: 1};
    tbl[4] = '{rot: 7,   exp_lag: 7,   hold: 3};
    tbl[5] = '{rot: 96,  exp_lag: 96,  hold: 0};

    tick();
    tick();
    check_reset_vals("reset");
    rst = 1'b0;
    tick();
    check_reset_vals("idle");

    // Table-driven sweeps.
    for (int i = 0; i < 6; i++) begin
      r = rand_word();
      sweep_to_valid(r, rotr(r, tbl[i].rot), tbl[i].exp_lag, $sformatf("tbl%0d", i));
      accept(tbl[i].hold, $sformatf("tbl%0d", i));
    end

    // Randomized sweeps against the reference model.
    for (int i = 0; i < 6; i++) begin
      r = rand_word();
      s = (i % 2 == 1) ? rotr(r, $urandom_range(0, N - 1)) : rand_word();
      sweep_to_valid(r, s, ref_lag(r, s), $sformatf("rnd%0d", i));
      accept($urandom_range(0, 3), $sformatf("rnd%0d", i));
    end

    // Backpressure: result held, start pulses in WAIT ignored.
    r = rand_word();
    sweep_to_valid(r, rotr(r, 40), 40, "bp");
    held = lag_out;
    bad  = 0;
    for (int i = 0; i < 20; i++) begin
      start   = (i % 3 == 0);
      din_ref = rand_word();
      din_sig = rand_word();
      tick();
      if (lag_out !== held || busy !== 1'b1 || arr_ena !== 1'b1 ||
          lag_valid !== 1'b1 || ref_out !== r)
        bad++;
    end
    start = 1'b0;
    check("bp_hold_bad_cycles", N'(bad), N'(0));
    accept(0, "bp");

    // Back-to-back: accept and restart on the same edge.
    r = rand_word();
    sweep_to_valid(r, rotr(r, 40), 40, "b2b_first");
    r2        = rand_word();
    din_ref   = r2;
    din_sig   = rotr(r2, 7);
    start     = 1'b1;
    lag_ready = 1'b1;
    tick();
    check("b2b_restart_busy", N'(busy), N'(1));
    check("b2b_restart_ena", N'(arr_ena), N'(0));
    check("b2b_restart_ref", ref_out, r2);
    din_ref = rand_word();
    din_sig = rand_word();
    cnt = 0;
    while (lag_valid !== 1'b1 && cnt < 60) begin
      cnt++;
      tick();
    end
    check("b2b_valid_low_cycles", N'(cnt), N'(NSTEP + 2));
    check("b2b_lag", N'(lag_out), N'(7));
    start = 1'b0;
    tick();
    lag_ready = 1'b0;
    check("b2b_end_busy", N'(busy), N'(0));

    // Reset mid-sweep at SWEEP k=10.
    r = rand_word();
    din_ref = r;
    din_sig = rotr(r, 5);
    start   = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    check("mid_k10_cnt", N'(arr_cnt), N'(40));
    rst = 1'b1;
    tick();
    check_reset_vals("midrst1");
    tick();
    check_reset_vals("midrst2");
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (lag_valid !== 1'b0 || busy !== 1'b0 || arr_ena !== 1'b1) bad++;
    end
    check("midrst_quiet_bad_cycles", N'(bad), N'(0));

`ifdef XCORR_SEQ_ABORT_EN
    r = rand_word();
    sweep_to_valid(r, rotr(r, 19), 19, "ab_prev");
    accept(0, "ab_prev");
    din_ref = rand_word();
    din_sig = rand_word();
    start   = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    check("ab_busy", N'(busy), N'(0));
    check("ab_ena", N'(arr_ena), N'(1));
    check("ab_cnt", N'(arr_cnt), N'(0));
    check("ab_lag_keep", N'(lag_out), N'(19));
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (lag_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("ab_quiet_bad_cycles", N'(bad), N'(0));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
